mux_sel_sequencer: RTL and testbench

MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

---
 rtl/mux_pkg.sv | 32 +++
 rtl/mux_sel_sequencer.sv | 155 +++++++++++++++
 tb/tb_mux_sel_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared types and constants for the mux select sequencer:
//               FSM state encoding, data/select/counter widths and the
//               select stepping helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int C_DATA_W = 8;
    localparam int C_SEL_W  = 3;
    localparam int C_CNT_W  = 4;

    localparam logic [C_SEL_W-1:0] C_SEL_MAX = 3'd7;
    localparam logic [C_SEL_W-1:0] C_SEL_MIN = 3'd0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Next select value: count down for MSB-first order, up otherwise.
    function automatic logic [C_SEL_W-1:0] sel_step(
        input logic [C_SEL_W-1:0] sel,
        input logic               down
    );
        return down ? (sel - C_SEL_W'(1)) : (sel + C_SEL_W'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_sel_sequencer
// Description : Serializes an 8-bit word by walking the select of an external
//               8:1 mux across the word and sampling the returned bit. Each
//               select value is held for BIT_CYCLES clocks; words may be
//               streamed back-to-back with no gap. Supports synchronous flush
//               of the word in progress.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_sequencer
    import mux_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [C_DATA_W-1:0] in_data,
    input  logic                flush,
    output logic [C_DATA_W-1:0] a,
    output logic [C_SEL_W-1:0]  s,
    input  logic                mux_out,
    output logic                ser_bit,
    output logic                ser_valid,
    output logic                ser_last,
    output logic                busy
);

    // Last count value of a bit period and the select loaded at word start.
    localparam logic [C_CNT_W-1:0] C_CNT_LAST  = C_CNT_W'(BIT_CYCLES - 1);
    localparam logic [C_SEL_W-1:0] C_SEL_FIRST = (MSB_FIRST != 0) ? C_SEL_MAX : C_SEL_MIN;
    localparam logic [C_SEL_W-1:0] C_IDX_LAST  = 3'd7;
    localparam logic               C_SEL_DOWN  = (MSB_FIRST != 0);

    state_t              r_state;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_SEL_W-1:0]  r_idx;
    logic [C_DATA_W-1:0] r_a;
    logic [C_SEL_W-1:0]  r_s;
    logic                r_ser_bit;
    logic                r_ser_valid;
    logic                r_ser_last;

    state_t              w_state_nxt;
    logic [C_CNT_W-1:0]  w_cnt_nxt;
    logic [C_SEL_W-1:0]  w_idx_nxt;
    logic [C_DATA_W-1:0] w_a_nxt;
    logic [C_SEL_W-1:0]  w_s_nxt;
    logic                w_ser_bit_nxt;
    logic                w_ser_valid_nxt;
    logic                w_ser_last_nxt;

    logic                w_period_end;
    logic                w_word_end;
    logic                w_accept;

    // A bit period ends when the counter reaches its last value while shifting;
    // the word ends on the period end of the eighth bit. A flush suppresses
    // both, so it also withholds the back-to-back ready.
    assign w_period_end = (r_state == ST_SHIFT) && (r_cnt == C_CNT_LAST) && !flush;
    assign w_word_end   = w_period_end && (r_idx == C_IDX_LAST);
    assign in_ready     = (r_state == ST_IDLE) || w_word_end;
    assign w_accept     = in_valid && in_ready;

    assign a         = r_a;
    assign s         = r_s;
    assign ser_bit   = r_ser_bit;
    assign ser_valid = r_ser_valid;
    assign ser_last  = r_ser_last;
    assign busy      = (r_state == ST_SHIFT);

    // Next-state and datapath update: sample/step, flush abort, word reload.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_a_nxt         = r_a;
        w_s_nxt         = r_s;
        w_ser_bit_nxt   = r_ser_bit;
        w_ser_valid_nxt = 1'b0;
        w_ser_last_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Loading is handled below, shared with the back-to-back path.
            end

            ST_SHIFT: begin
                if (flush) begin
                    // Abort: a and s hold, no sample this cycle.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (w_period_end) begin
                    w_ser_bit_nxt   = mux_out;
                    w_ser_valid_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_idx_nxt       = r_idx + C_SEL_W'(1);
                    if (r_idx == C_IDX_LAST) begin
                        // Select is left on the final bit; only a reload moves it.
                        w_ser_last_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_s_nxt = sel_step(r_s, C_SEL_DOWN);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase

        // Accepting a word overrides the end-of-word return to idle.
        if (w_accept) begin
            w_state_nxt = ST_SHIFT;
            w_a_nxt     = in_data;
            w_s_nxt     = C_SEL_FIRST;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_a         <= '0;
            r_s         <= '0;
            r_ser_bit   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_a         <= w_a_nxt;
            r_s         <= w_s_nxt;
            r_ser_bit   <= w_ser_bit_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_ser_last  <= w_ser_last_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_sel_sequencer
// Description : Self-checking bench for mux_sel_sequencer. Three instances
//               (LSB-first x1, MSB-first x1, LSB-first x3) each drive a
//               behavioural 8:1 mux. Expected pulses (instance, cycle, bit,
//               last) are queued when a word is driven and popped on every
//               ser_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_sequencer;

    localparam int C_N = 3;

    typedef struct {
        int   inst;
        int   cyc;
        logic b;
        logic last;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       iv    [C_N];
    logic       ir    [C_N];
    logic [7:0] id    [C_N];
    logic       fl    [C_N];
    logic [7:0] av    [C_N];
    logic [2:0] sel   [C_N];
    logic       mo    [C_N];
    logic       sb_b  [C_N];
    logic       sv    [C_N];
    logic       sl    [C_N];
    logic       bsy   [C_N];

    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    for (genvar g = 0; g < C_N; g++) begin : g_dut
        mux_sel_sequencer #(
            .BIT_CYCLES ((g == 2) ? 3 : 1),
            .MSB_FIRST  ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (id[g]),
            .flush     (fl[g]),
            .a         (av[g]),
            .s         (sel[g]),
            .mux_out   (mo[g]),
            .ser_bit   (sb_b[g]),
            .ser_valid (sv[g]),
            .ser_last  (sl[g]),
            .busy      (bsy[g])
        );
        // Downstream 8:1 mux model.
        assign mo[g] = av[g][sel[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so each pulse can be matched to its expected cycle.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the expected pulses of a word accepted on rising edge edge_n.
    task automatic push_word(input int inst, input int edge_n, input logic [7:0] d,
                             input int bc, input int msb, input int nbits);
        exp_t e;
        for (int j = 0; j < nbits; j++) begin
            e.inst = inst;
            e.cyc  = edge_n + bc * (j + 1);
            e.b    = d[(msb != 0) ? (7 - j) : j];
            e.last = (j == 7);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic chk_reset(input int i);
        chk("rst_a",     av[i],   8'h00);
        chk("rst_s",     sel[i],  3'd0);
        chk("rst_bit",   sb_b[i], 1'b0);
        chk("rst_valid", sv[i],   1'b0);
        chk("rst_last",  sl[i],   1'b0);
        chk("rst_busy",  bsy[i],  1'b0);
    endtask

    // Scoreboard: every ser_valid must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < C_N; i++) begin
            if (sv[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("pulse_expected", 32'(sb.size() != 0), 1);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_inst", i,       e.inst);
                    chk("pulse_cyc",  cyc,     e.cyc);
                    chk("pulse_bit",  sb_b[i], e.b);
                    chk("pulse_last", sl[i],   e.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < C_N; i++) begin
            iv[i] = 1'b0;
            id[i] = 8'h00;
            fl[i] = 1'b0;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        for (int i = 0; i < C_N; i++) chk_reset(i);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < C_N; i++) begin
            chk("ready_after_reset", ir[i], 1'b1);
            chk("busy_after_reset",  bsy[i], 1'b0);
        end

        // LSB-first 8'hA5, select walks 0..7.
        @(negedge clk);
        iv[0] = 1'b1; id[0] = 8'hA5;
        push_word(0, cyc + 1, 8'hA5, 1, 0, 8);
        @(negedge clk);
        iv[0] = 1'b0;
        chk("lsb_a", av[0], 8'hA5);
        chk("lsb_busy", bsy[0], 1'b1);
        chk("lsb_s0", sel[0], 3'd0);
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            chk("lsb_s", sel[0], 32'(j));
        end
        drain(20);

        // MSB-first 8'hA5, select walks 7..0.
        @(negedge clk);
        iv[1] = 1'b1; id[1] = 8'hA5;
        push_word(1, cyc + 1, 8'hA5, 1, 1, 8);
        @(negedge clk);
        iv[1] = 1'b0;
        chk("msb_s0", sel[1], 3'd7);
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            chk("msb_s", sel[1], 32'(7 - j));
        end
        drain(20);

        // Three cycles per bit, 8'h01: 24-cycle word.
        @(negedge clk);
        iv[2] = 1'b1; id[2] = 8'h01;
        push_word(2, cyc + 1, 8'h01, 3, 0, 8);
        @(negedge clk);
        iv[2] = 1'b0;
        drain(40);
        chk("bc3_busy_end",  bsy[2], 1'b0);
        chk("bc3_ready_end", ir[2],  1'b1);

        // Back-to-back 8'hFF then 8'h00 with in_valid held high.
        @(negedge clk);
        iv[0] = 1'b1; id[0] = 8'hFF;
        push_word(0, cyc + 1, 8'hFF, 1, 0, 8);
        push_word(0, cyc + 9, 8'h00, 1, 0, 8);
        @(negedge clk);
        id[0] = 8'h00;
        repeat (8) @(negedge clk);
        iv[0] = 1'b0;
        chk("b2b_busy", bsy[0], 1'b1);
        chk("b2b_a", av[0], 8'h00);
        drain(20);

        // Flush after the third pulse of 8'h3C.
        @(negedge clk);
        iv[0] = 1'b1; id[0] = 8'h3C;
        push_word(0, cyc + 1, 8'h3C, 1, 0, 3);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        fl[0] = 1'b1;
        @(negedge clk);
        fl[0] = 1'b0;
        chk("flush_busy",  bsy[0], 1'b0);
        chk("flush_ready", ir[0],  1'b1);
        chk("flush_s_hold", sel[0], 3'd3);
        chk("flush_a_hold", av[0],  8'h3C);
        repeat (5) @(negedge clk);
        chk("flush_no_pulses", sb.size(), 0);

        // Flush while idle must not block accepting 8'hC3.
        iv[0] = 1'b1; id[0] = 8'hC3; fl[0] = 1'b1;
        push_word(0, cyc + 1, 8'hC3, 1, 0, 8);
        @(negedge clk);
        iv[0] = 1'b0; fl[0] = 1'b0;
        drain(20);

        // Reset after the fifth bit of 8'h5A.
        @(negedge clk);
        iv[0] = 1'b1; id[0] = 8'h5A;
        push_word(0, cyc + 1, 8'h5A, 1, 0, 5);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset_no_pulses", sb.size(), 0);
        chk("reset_ready", ir[0], 1'b1);

        // Fresh word after reset.
        iv[0] = 1'b1; id[0] = 8'h96;
        push_word(0, cyc + 1, 8'h96, 1, 0, 8);
        @(negedge clk);
        iv[0] = 1'b0;
        drain(20);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
